// File: rtl/rx_buffer.sv
// rx_buffer: show-ahead elastic FIFO behind the UART receiver.
// Holds {perr,data} frames and keeps overrun and parity status.
module rx_buffer #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_perr,
    input  logic          out_ready,
    input  logic          clr_stat,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic          out_perr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf,
    output logic [7:0]    perr_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic         perr;
        logic [W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            rd;
    logic            wr;
    logic            drop;
    logic            perr_hit;
    logic            perr_sat;
    entry_t          head;

    // Handshake decode; a full buffer still accepts when the head pops.
    always_comb begin
        out_valid = (count != '0);
        full      = (count == CW'(DEPTH));
        rd        = out_valid & out_ready;
        wr        = in_valid & (~full | rd);
        drop      = in_valid & full & ~rd;
        perr_hit  = wr & in_perr;
        perr_sat  = (perr_cnt == 8'hFF);
        head      = mem[rp];
        out_data  = head.data;
        out_perr  = head.perr;
    end

    // Frame storage; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= '{perr: in_perr, data: in_data};
        end
    end

    // Pointers and occupancy; count is kept separately so full is exact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wp <= wp + AW'(1);
            end
            if (rd) begin
                rp <= rp + AW'(1);
            end
            unique case (1'b1)
                wr & ~rd: count <= count + CW'(1);
                rd & ~wr: count <= count - CW'(1);
                default:  count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the clearing cycle still sets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_stat) begin
            ovf <= 1'b0;
        end
    end

    // Saturating parity-error counter; a counted write beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_cnt <= 8'd0;
        end else if (perr_hit) begin
            if (clr_stat) begin
                perr_cnt <= 8'd1;
            end else if (!perr_sat) begin
                perr_cnt <= perr_cnt + 8'd1;
            end
        end else if (clr_stat) begin
            perr_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_rx_buffer.sv
// tb_rx_buffer: directed checks for rx_buffer.
// Linear stimulus, hand-computed expectations, assert per check.
module tb_rx_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_perr = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_stat = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_perr;
    logic [2:0] count;
    logic       full;
    logic       ovf;
    logic [7:0] perr_cnt;

    int checks = 0;
    int passed = 0;

    rx_buffer #(.W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_perr   (in_perr),
        .out_ready (out_ready),
        .clr_stat  (clr_stat),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .count     (count),
        .full      (full),
        .ovf       (ovf),
        .perr_cnt  (perr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_perr  = p;
        step();
        in_valid = 1'b0;
        in_perr  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        step();
    endtask

    initial begin
        // reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_perr", 32'(perr_cnt), 32'd0);
        step();
        rst = 1'b1;
        step();

        // fill
        push(8'hA1, 1'b0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'hA1);
        push(8'hB2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hD4, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovf", 32'(ovf), 32'd0);

        // overrun drops 0xEE
        push(8'hEE, 1'b0);
        check("ovr_ovf", 32'(ovf), 32'd1);
        check("ovr_count", 32'(count), 32'd4);

        // drain
        out_ready = 1'b1;
        pop_expect("drain0", 8'hA1);
        pop_expect("drain1", 8'hB2);
        pop_expect("drain2", 8'hC3);
        pop_expect("drain3", 8'hD4);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // clear
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);

        // full with simultaneous read and write
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hD4, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        check("rw_head", 32'(out_data), 32'hA1);
        step();
        in_valid = 1'b0;
        check("rw_ovf", 32'(ovf), 32'd0);
        check("rw_count", 32'(count), 32'd4);
        check("rw_full", 32'(full), 32'd1);
        pop_expect("rw1", 8'hB2);
        pop_expect("rw2", 8'hC3);
        pop_expect("rw3", 8'hD4);
        pop_expect("rw4", 8'h55);
        check("rw_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // parity flags
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        check("par_cnt", 32'(perr_cnt), 32'd2);
        out_ready = 1'b1;
        check("par_p0", 32'(out_perr), 32'd1);
        pop_expect("par0", 8'h11);
        check("par_p1", 32'(out_perr), 32'd0);
        pop_expect("par1", 8'h22);
        check("par_p2", 32'(out_perr), 32'd1);
        pop_expect("par2", 8'h33);

        // saturation: 300 errored writes streaming through
        in_valid = 1'b1;
        in_perr  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        in_perr  = 1'b0;
        step();
        check("sat_cnt", 32'(perr_cnt), 32'd255);
        check("sat_count", 32'(count), 32'd0);
        check("sat_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b0;

        // clear alone, then clear with errored write
        clr_stat = 1'b1;
        step();
        check("clr_perr", 32'(perr_cnt), 32'd0);
        push(8'h77, 1'b1);
        clr_stat = 1'b0;
        check("clrw_perr", 32'(perr_cnt), 32'd1);
        check("clrw_count", 32'(count), 32'd1);

        // drop during clear sets ovf, drop not counted
        push(8'h78, 1'b0);
        push(8'h79, 1'b0);
        push(8'h7A, 1'b0);
        clr_stat = 1'b1;
        push(8'h7B, 1'b1);
        clr_stat = 1'b0;
        check("clrd_ovf", 32'(ovf), 32'd1);
        check("clrd_perr", 32'(perr_cnt), 32'd0);
        check("clrd_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        pop_expect("clrd0", 8'h77);
        pop_expect("clrd1", 8'h78);
        pop_expect("clrd2", 8'h79);
        pop_expect("clrd3", 8'h7A);
        check("clrd_empty", 32'(out_valid), 32'd0);

        // empty pass-through with ready held
        push(8'h3C, 1'b0);
        check("pt_valid", 32'(out_valid), 32'd1);
        check("pt_data", 32'(out_data), 32'h3C);
        step();
        check("pt_gone", 32'(out_valid), 32'd0);
        check("pt_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // async reset mid-operation
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        check("mid_count", 32'(count), 32'd3);
        check("mid_perr", 32'(perr_cnt), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_perr", 32'(perr_cnt), 32'd0);
        step();
        #2;
        rst = 1'b1;
        step();
        push(8'h9A, 1'b0);
        check("post_count", 32'(count), 32'd1);
        check("post_data", 32'(out_data), 32'h9A);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rx_buffer.md
# rx_buffer

Receive-side elastic buffer sitting directly downstream of the UART receiver. Captures each completed frame (data word plus parity-error flag) on a one-cycle strobe, stores it in a show-ahead FIFO, and presents it to the consumer over a valid/ready handshake. It tracks occupancy, records overruns in a sticky flag, and keeps a saturating count of parity-errored frames for status readback.

## Interface
- W, 8, data word width; matches receiver W.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  one-cycle strobe from receiver: frame complete.
- in_data  in  W  received word, sampled when in_valid=1.
- in_perr  in  1  parity error for this frame (tie 0 when PAR=0).
- out_ready  in  1  consumer accepts head entry this cycle.
- clr_stat  in  1  clears ovf and perr_cnt.
- out_valid  out  1  FIFO non-empty; head entry valid.
- out_data  out  W  head entry data.
- out_perr  out  1  head entry parity flag.
- count  out  CW  entries held, 0..DEPTH.
- full  out  1  count==DEPTH.
- ovf  out  1  sticky: a frame was dropped.
- perr_cnt  out  8  saturating count of accepted frames with in_perr=1.

## Operation
- Storage: DEPTH×(W+1) register array, write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count held as a separate CW-bit register.
- Read: rd = out_valid & out_ready. Pops head: rp←rp+1, count decrements.
- Write: wr = in_valid & (~full | rd). Stores {in_perr,in_data} at wp, wp←wp+1.
- Count update: wr&~rd → +1; rd&~wr → −1; both or neither → unchanged.
- Full with simultaneous in_valid and rd: write accepted (slot freed same edge), count stays DEPTH, ovf not set.
- Full, in_valid, no rd: frame dropped, memory/pointers unchanged, ovf←1.
- Empty with in_valid: write accepted; out_ready ignored since out_valid=0.
- perr_cnt: increments on wr & in_perr; saturates at 255; dropped frames never counted.
- clr_stat: clears ovf and perr_cnt. Same-cycle set event (drop, or counted write) wins: ovf←1 / perr_cnt←1.
- out_data/out_perr: combinational read of mem[rp]; value undefined-but-stable when out_valid=0 (bench must not check it then).

## Timing
- Reset (rst=0, async): wp=rp=0, count=0, out_valid=0, full=0, ovf=0, perr_cnt=0; memory contents not reset.
- Reset release mid-traffic: no partial state; first in_valid after release is the first stored entry.
- Write latency: in_valid at edge N → out_valid=1 and head data visible after edge N (cycle N+1) when previously empty.
- Read: pop completes at the edge where out_valid&out_ready; next entry (or out_valid=0) visible the following cycle.
- Sustained throughput: one write and one read per cycle concurrently at any occupancy.
- ovf rises the cycle after the dropping edge; perr_cnt updates the cycle after the write edge.
- in_valid is a single-cycle pulse; multi-cycle assertion is treated as one write per cycle.

## Test plan
- Reset: drive rst=0 mid-operation with count=3 → all outputs immediately 0 (count=0, out_valid=0, ovf=0, perr_cnt=0) without clock edge.
- Fill/drain, DEPTH=4: write 0xA1,0xB2,0xC3,0xD4 with out_ready=0 → full=1, count=4; then out_ready=1 → out_data A1,B2,C3,D4 on consecutive cycles, then out_valid=0, count=0.
- Overrun: full with 4 entries, in_valid with 0xEE, out_ready=0 → ovf=1, count=4, subsequent reads return A1..D4 (0xEE absent).
- Full + simultaneous read/write: full, in_valid 0x55 with out_ready=1 → ovf=0, count=4, 0x55 emerges as fifth read after wraparound.
- Parity stats: write 3 frames with in_perr=1,0,1 → perr_cnt=2, out_perr sequence 1,0,1; 300 errored writes with continuous reads → perr_cnt=255; clr_stat alone → 0; clr_stat with errored write → 1.
- Empty pass-through: empty FIFO, in_valid 0x3C with out_ready held 1 → out_valid high exactly one cycle after write, data 0x3C, then out_valid=0.
